// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the parallel TX/RX word handshake of spi_slave.
interface spi_slave_if #(parameter int N = 8);
    logic         sck_i;
    logic         cs_n_i;
    logic         mosi_i;
    logic         miso_o;
    logic [N-1:0] txData_i;
    logic         txLoad_i;
    logic [N-1:0] rxData_o;
    logic         rxValid_o;
    logic         busy_o;
    logic         frameErr_o;
    modport slave (
        input  sck_i, cs_n_i, mosi_i, txData_i, txLoad_i,
        output miso_o, rxData_o, rxValid_o, busy_o, frameErr_o
    );
    modport master (
        output sck_i, cs_n_i, mosi_i, txData_i, txLoad_i,
        input  miso_o, rxData_o, rxValid_o, busy_o, frameErr_o
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave (idle-high sck, sample on rise, shift on fall).
// Pins are synchronized to clk_c; words are N bits, MSB first, back-to-back capable.
module spi_slave #(
    parameter int N = 8
) (
    input logic       clk_c,
    input logic       reset_r,
    spi_slave_if.slave spi
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e          state_q;
    logic [2:0]      sck_q, cs_q, vld_q;
    logic [1:0]      mosi_q;
    logic            sck_rise_q, sck_fall_q, cs_fall_q, cs_rise_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [N-1:0]    tx_buf_q, tx_shift_q, rx_shift_q, rx_data_q;
    logic            rx_valid_q, miso_q, frame_err_q;

    assign spi.miso_o     = miso_q;
    assign spi.rxData_o   = rx_data_q;
    assign spi.rxValid_o  = rx_valid_q;
    assign spi.busy_o     = state_q == ACTIVE;
    assign spi.frameErr_o = frame_err_q;

    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            sck_q       <= '1;
            cs_q        <= '1;
            mosi_q      <= '0;
            vld_q       <= '0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_buf_q    <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sck_q       <= {sck_q[1:0], spi.sck_i};
            cs_q        <= {cs_q[1:0], spi.cs_n_i};
            mosi_q      <= {mosi_q[0], spi.mosi_i};
            // vld_q masks the reset-forced 1s so a cs_n held low across reset is not a fall
            vld_q       <= {vld_q[1:0], 1'b1};
            sck_rise_q  <= sck_q[1] & ~sck_q[2];
            sck_fall_q  <= ~sck_q[1] & sck_q[2];
            cs_fall_q   <= ~cs_q[1] & cs_q[2] & vld_q[2];
            cs_rise_q   <= cs_q[1] & ~cs_q[2];
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (spi.txLoad_i)
                tx_buf_q <= spi.txData_i;
            if (state_q == IDLE) begin
                miso_q <= 1'b0;
                if (cs_fall_q) begin
                    state_q    <= ACTIVE;
                    bit_cnt_q  <= '0;
                    tx_shift_q <= tx_buf_q;
                    miso_q     <= tx_buf_q[N-1];
                end
            end else if (cs_rise_q) begin
                state_q     <= IDLE;
                miso_q      <= 1'b0;
                frame_err_q <= bit_cnt_q != '0;
            end else begin
                if (sck_rise_q) begin
                    rx_shift_q <= {rx_shift_q[N-2:0], mosi_q[1]};
                    bit_cnt_q  <= bit_cnt_q == LAST ? '0 : bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST) begin
                        rx_data_q  <= {rx_shift_q[N-2:0], mosi_q[1]};
                        rx_valid_q <= 1'b1;
                    end
                end
                // miso_q follows the new txShift MSB so it never lags the shifter
                if (sck_fall_q) begin
                    tx_shift_q <= bit_cnt_q == '0 ? tx_buf_q : {tx_shift_q[N-2:0], 1'b0};
                    miso_q     <= bit_cnt_q == '0 ? tx_buf_q[N-1] : tx_shift_q[N-2];
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives an SPI master model against spi_slave and checks words,
// pulses and latency against expectations derived at word level.
module tb_spi_slave;
    localparam int N = 8;

    logic clk_c = 1'b0;
    logic reset_r = 1'b1;

    spi_slave_if #(.N(N)) bus ();
    spi_slave #(.N(N)) dut (.clk_c(clk_c), .reset_r(reset_r), .spi(bus));

    always #5 clk_c = ~clk_c;

    int cyc = 0;
    always @(posedge clk_c) cyc++;

    int n_chk = 0, n_pass = 0;
    logic [7:0] rx_q[$];
    int val_cnt = 0, err_cnt = 0, rise_cyc = 0, lat = 0;

    always @(negedge clk_c) begin
        if (bus.rxValid_o) begin
            rx_q.push_back(bus.rxData_o);
            val_cnt++;
            lat = cyc - rise_cyc;
        end
        if (bus.frameErr_o) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_c);
    endtask

    task automatic clear();
        rx_q.delete();
        val_cnt = 0;
        err_cnt = 0;
    endtask

    function automatic logic [31:0] pop();
        return rx_q.size() != 0 ? {24'h0, rx_q.pop_front()} : 32'hxxxx_xxxx;
    endfunction

    task automatic load(input logic [7:0] v);
        bus.txData_i = v;
        bus.txLoad_i = 1'b1;
        tick(1);
        bus.txLoad_i = 1'b0;
    endtask

    task automatic cs_lo();
        bus.cs_n_i = 1'b0;
        tick(6);
    endtask

    task automatic cs_hi();
        tick(6);
        bus.cs_n_i = 1'b1;
        tick(8);
    endtask

    // mode-3 master, sck = clk/8; lb selects a bit whose fall coincides with a txLoad
    task automatic bits(input int n, input logic [15:0] mo, input int lb,
                        input logic [7:0] lv, output logic [15:0] mi);
        mi = '0;
        for (int b = 0; b < n; b++) begin
            bus.sck_i  = 1'b0;
            bus.mosi_i = mo[n-1-b];
            if (b == lb) begin
                tick(3);
                bus.txData_i = lv;
                bus.txLoad_i = 1'b1;
                tick(1);
                bus.txLoad_i = 1'b0;
            end else tick(4);
            bus.sck_i = 1'b1;
            mi = {mi[14:0], bus.miso_o};
            rise_cyc = cyc;
            tick(4);
        end
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_rxdata"}, {24'h0, bus.rxData_o}, 32'h0);
        check({tag, "_rxvalid"}, {31'h0, bus.rxValid_o}, 32'h0);
        check({tag, "_miso"}, {31'h0, bus.miso_o}, 32'h0);
        check({tag, "_busy"}, {31'h0, bus.busy_o}, 32'h0);
        check({tag, "_ferr"}, {31'h0, bus.frameErr_o}, 32'h0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] mi;
        logic [7:0]  t0, t1, m0, m1;
        int          lb;
        bus.sck_i = 1'b1;
        bus.cs_n_i = 1'b1;
        bus.mosi_i = 1'b0;
        bus.txData_i = '0;
        bus.txLoad_i = 1'b0;
        tick(3);
        outs_zero("reset");
        reset_r = 1'b0;
        tick(4);

        clear();
        load(8'hA5);
        cs_lo();
        check("single_busy", {31'h0, bus.busy_o}, 32'h1);
        bits(8, 16'h003C, -1, 8'h0, mi);
        cs_hi();
        check("single_cnt", val_cnt, 1);
        check("single_rx", pop(), 32'h3C);
        check("single_miso", {16'h0, mi}, 32'hA5);
        check("single_lat", lat, 4);
        check("single_idle", {31'h0, bus.busy_o}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            clear();
            t0 = 8'($urandom);
            m0 = 8'($urandom);
            load(t0);
            cs_lo();
            bits(8, {8'h0, m0}, -1, 8'h0, mi);
            cs_hi();
            check("rand_cnt", val_cnt, 1);
            check("rand_rx", pop(), {24'h0, m0});
            check("rand_miso", {16'h0, mi}, {24'h0, t0});
        end

        clear();
        load(8'h11);
        cs_lo();
        bits(16, 16'hF00F, 3, 8'h22, mi);
        cs_hi();
        check("b2b_cnt", val_cnt, 2);
        check("b2b_rx0", pop(), 32'hF0);
        check("b2b_rx1", pop(), 32'h0F);
        check("b2b_miso", {16'h0, mi}, 32'h1122);

        for (int i = 0; i < 4; i++) begin
            clear();
            t0 = 8'($urandom);
            t1 = 8'($urandom);
            m0 = 8'($urandom);
            m1 = 8'($urandom);
            lb = int'($urandom_range(1, 7));
            load(t0);
            cs_lo();
            bits(16, {m0, m1}, lb, t1, mi);
            cs_hi();
            check("rb2b_cnt", val_cnt, 2);
            check("rb2b_rx0", pop(), {24'h0, m0});
            check("rb2b_rx1", pop(), {24'h0, m1});
            check("rb2b_miso", {16'h0, mi}, {16'h0, t0, t1});
        end

        // load on the very cycle of a word-boundary reload: old value goes out, new one next frame
        clear();
        t0 = 8'($urandom);
        t1 = ~t0;
        load(t0);
        cs_lo();
        bits(8, 16'h0055, 0, t1, mi);
        cs_hi();
        check("coinc_miso", {16'h0, mi}, {24'h0, t0});
        cs_lo();
        bits(8, 16'h00AA, -1, 8'h0, mi);
        cs_hi();
        check("retx_miso1", {16'h0, mi}, {24'h0, t1});
        cs_lo();
        bits(8, 16'h0033, -1, 8'h0, mi);
        cs_hi();
        check("retx_miso2", {16'h0, mi}, {24'h0, t1});
        check("retx_cnt", val_cnt, 3);

        clear();
        cs_lo();
        bits(5, 16'h001B, -1, 8'h0, mi);
        cs_hi();
        check("abort_ferr", err_cnt, 1);
        check("abort_valid", val_cnt, 0);
        check("abort_busy", {31'h0, bus.busy_o}, 32'h0);
        m0 = 8'($urandom);
        t0 = 8'($urandom);
        load(t0);
        cs_lo();
        bits(8, {8'h0, m0}, -1, 8'h0, mi);
        cs_hi();
        check("post_abort_rx", pop(), {24'h0, m0});
        check("post_abort_miso", {16'h0, mi}, {24'h0, t0});
        check("post_abort_ferr", err_cnt, 1);

        clear();
        load(8'hC3);
        cs_lo();
        bits(3, 16'h0005, -1, 8'h0, mi);
        reset_r = 1'b1;
        tick(1);
        outs_zero("midrst");
        reset_r = 1'b0;
        tick(2);
        bits(8, 16'h0077, -1, 8'h0, mi);
        tick(6);
        check("midrst_novalid", val_cnt, 0);
        check("midrst_busy", {31'h0, bus.busy_o}, 32'h0);
        cs_hi();
        check("midrst_noferr", err_cnt, 0);
        m0 = 8'($urandom);
        cs_lo();
        bits(8, {8'h0, m0}, -1, 8'h0, mi);
        cs_hi();
        check("midrst_rx", pop(), {24'h0, m0});
        check("midrst_miso", {16'h0, mi}, 32'h0);

        clear();
        load(8'hFF);
        bits(8, 16'h00A5, -1, 8'h0, mi);
        tick(6);
        check("idle_valid", val_cnt, 0);
        check("idle_miso", {16'h0, mi}, 32'h0);
        check("idle_busy", {31'h0, bus.busy_o}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
